// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - issues one command at a time to an external combinational ALU
// and holds the captured result until the consumer accepts it.
module alu_issuer #(
  parameter int CNT_W  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_acc,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic [2:0]       alu_sel_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_valid_q;
  logic [7:0]       acc_q;
  logic [CNT_W-1:0] op_count_q;

  logic [7:0]       alu_a_d;
  logic [CNT_W-1:0] op_count_d;

  assign alu_a_d    = ((ACC_EN != 0) && cmd_acc) ? acc_q : cmd_a;
  assign op_count_d = op_count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 3'd0;
      rsp_data_q  <= 8'h00;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      acc_q       <= 8'h00;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= cmd_b;
            alu_sel_q <= cmd_op;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had a full cycle to settle on the registered operands.
          rsp_data_q  <= alu_out;
          acc_q       <= alu_out;
          rsp_zero_q  <= (alu_out == 8'h00);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Depends only on state and reset, never on rsp_ready.
  assign cmd_ready = (state_q == IDLE) && !rst;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign op_count  = op_count_q;

endmodule
